// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: multi-lane registered immediate generator for the decode stage.
// Decodes up to LANES immediates per cycle and sign-extends each one to XLEN.
// CSR zimm is zero-extended. The outputs are registered behind a 2-entry skid
// buffer (main reg M drives outputs, skid reg S catches one extra bundle), so
// in_ready has no combinational path from out_ready.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous kill of all buffered bundles
//   in_valid      upstream bundle valid
//   in_ready      stage can accept a bundle this cycle (registered)
//   in_lane_vld   per-lane valid inside the bundle
//   in_inst       raw instructions, lane i at [32*i +: 32]
//   in_imm_sel    ImmSel per lane, lane i at [3*i +: 3]
//   out_valid     registered bundle valid
//   out_ready     downstream accepts the bundle
//   out_lane_vld  registered per-lane valid
//   out_imm       immediates, lane i at [XLEN*i +: XLEN]
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_vld,
  input  logic [LANES*32-1:0]   in_inst,
  input  logic [LANES*3-1:0]    in_imm_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [LANES*XLEN-1:0] out_imm
);

  typedef enum logic [2:0] {
    I_TYPE_IMM = 3'd0,
    S_TYPE_IMM = 3'd1,
    B_TYPE_IMM = 3'd2,
    U_TYPE_IMM = 3'd3,
    J_TYPE_IMM = 3'd4,
    Z_TYPE_IMM = 3'd5
  } imm_sel_e;

  logic [LANES*XLEN-1:0] inc_imm;
  logic [31:0]           inst;
  logic [31:0]           imm32;

  // Every format is first built as a 32-bit value whose bit 31 is the correct
  // sign (zero for zimm), then widened with a signed cast to reach XLEN.
  always_comb begin
    inc_imm = '0;
    inst    = '0;
    imm32   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      inst = in_inst[32*i +: 32];
      case (imm_sel_e'(in_imm_sel[3*i +: 3]))
        I_TYPE_IMM: imm32 = {{20{inst[31]}}, inst[31:20]};
        S_TYPE_IMM: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        B_TYPE_IMM: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        J_TYPE_IMM: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        U_TYPE_IMM: imm32 = {inst[31:12], 12'b0};
        Z_TYPE_IMM: imm32 = {27'b0, inst[19:15]};
        default:    imm32 = '0;
      endcase
      if (in_lane_vld[i]) begin
        inc_imm[XLEN*i +: XLEN] = XLEN'($signed(imm32));
      end
    end
  end

  logic                  m_valid, s_valid;
  logic [LANES-1:0]      m_lv, s_lv;
  logic [LANES*XLEN-1:0] m_imm, s_imm;
  logic                  accept, drain;

  assign in_ready     = ~s_valid;
  assign accept       = in_valid & ~s_valid;
  assign drain        = m_valid & out_ready;
  assign out_valid    = m_valid;
  assign out_lane_vld = m_lv;
  assign out_imm      = m_imm;

  // accept implies S is empty, so the S->M refill branch never sees an
  // incoming bundle in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_lv    <= '0;
      s_lv    <= '0;
      m_imm   <= '0;
      s_imm   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (drain && s_valid) begin
      m_lv    <= s_lv;
      m_imm   <= s_imm;
      s_valid <= 1'b0;
    end else if (accept && (!m_valid || drain)) begin
      m_valid <= 1'b1;
      m_lv    <= in_lane_vld;
      m_imm   <= inc_imm;
    end else if (accept) begin
      s_valid <= 1'b1;
      s_lv    <= in_lane_vld;
      s_imm   <= inc_imm;
    end else if (drain) begin
      m_valid <= 1'b0;
    end
  end

endmodule
